// File: rtl/rx_phase_ctrl_if.sv
// Signal bundle between the phase-sweep controller and its requester/receive filter.
// master drives start and detection; slave is the controller.
interface rx_phase_ctrl_if #(
  parameter int unsigned ERR_BITS = 11
);
  logic                i_start;
  logic                i_detection;
  logic                o_enable;
  logic [1:0]          o_phase;
  logic                o_busy;
  logic                o_locked;
  logic [1:0]          o_best_phase;
  logic [ERR_BITS-1:0] o_min_err;

  modport master (
    output i_start, i_detection,
    input  o_enable, o_phase, o_busy, o_locked, o_best_phase, o_min_err
  );

  modport slave (
    input  i_start, i_detection,
    output o_enable, o_phase, o_busy, o_locked, o_best_phase, o_min_err
  );
endinterface

// File: rtl/rx_phase_ctrl.sv
// Receive-filter phase sweep: strobes the filter, scores each of 4 phases on PRBS9 errors
// and locks onto the best. Define RX_PHASE_CTRL_TRACK_EN for in-lock error tracking.
module rx_phase_ctrl #(
  parameter int unsigned N_DIV    = 4,
  parameter int unsigned SETTLE   = 16,
  parameter int unsigned WINDOW   = 1024,
  parameter int unsigned ERR_BITS = $clog2(WINDOW + 1),
  parameter int unsigned THRESH   = 8
) (
  input logic            clk,
  input logic            rst,
  rx_phase_ctrl_if.slave bus
);

`ifdef RX_PHASE_CTRL_TRACK_EN
  localparam bit TrackEn = 1'b1;
`else
  localparam bit TrackEn = 1'b0;
`endif

  localparam int unsigned DivW   = (N_DIV > 1) ? $clog2(N_DIV) : 1;
  localparam int unsigned CntMax = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [DivW-1:0]     DivLast    = DivW'(N_DIV - 1);
  localparam logic [CntW-1:0]     SettleLast = CntW'(SETTLE - 1);
  localparam logic [CntW-1:0]     WindowLast = CntW'(WINDOW - 1);
  localparam logic [ERR_BITS-1:0] ErrMax     = '1;

  typedef enum logic [2:0] {StIdle, StSettle, StCount, StEval, StLock} state_e;

  logic [DivW-1:0] div_q;
  logic            enable_q;
  logic [1:0]      sym_q;
  logic            tick_q;
  logic [8:0]      hist_q;
  logic            sample_err;

  state_e              state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ERR_BITS-1:0] err_q, err_d;
  logic [ERR_BITS-1:0] err_inc;
  logic [1:0]          best_q, best_d;
  logic [ERR_BITS-1:0] best_err_q, best_err_d;
  logic [1:0]          lock_phase_q, lock_phase_d;
  logic [ERR_BITS-1:0] lock_err_q, lock_err_d;
  logic                sweep;
  logic                better;

  // Enable divider and symbol tick run regardless of the sweep state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      enable_q <= 1'b0;
      sym_q    <= 2'd0;
      tick_q   <= 1'b0;
      hist_q   <= '0;
    end else begin
      div_q    <= (div_q == DivLast) ? '0 : div_q + 1'b1;
      enable_q <= (div_q == DivLast);
      if (enable_q) sym_q <= sym_q + 2'd1;
      tick_q   <= enable_q && (sym_q == 2'd3);
      if (tick_q) hist_q <= {hist_q[7:0], bus.i_detection};
    end
  end

  // Self-synchronising PRBS9 check: x^9 + x^5 + 1 against the sampled history.
  assign sample_err = bus.i_detection ^ hist_q[8] ^ hist_q[4];
  assign err_inc    = (err_q == ErrMax) ? err_q : err_q + ERR_BITS'(sample_err);
  assign better     = (err_q < best_err_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      phase_q      <= 2'd0;
      cnt_q        <= '0;
      err_q        <= '0;
      best_q       <= 2'd0;
      best_err_q   <= '0;
      lock_phase_q <= 2'd0;
      lock_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      best_q       <= best_d;
      best_err_q   <= best_err_d;
      lock_phase_q <= lock_phase_d;
      lock_err_q   <= lock_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    best_d       = best_q;
    best_err_d   = best_err_q;
    lock_phase_d = lock_phase_q;
    lock_err_d   = lock_err_q;
    sweep        = 1'b0;

    unique case (state_q)
      StIdle: sweep = bus.i_start;
      StSettle: begin
        if (tick_q) begin
          if (cnt_q == SettleLast) begin
            state_d = StCount;
            cnt_d   = '0;
            err_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StCount: begin
        if (tick_q) begin
          err_d = err_inc;
          if (cnt_q == WindowLast) begin
            state_d = StEval;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StEval: begin
        // Strict compare: on a tie the earlier (lower) phase is kept.
        if (better) begin
          best_d     = phase_q;
          best_err_d = err_q;
        end
        if (phase_q == 2'd3) begin
          state_d      = StLock;
          lock_phase_d = better ? phase_q : best_q;
          lock_err_d   = better ? err_q : best_err_q;
          cnt_d        = '0;
          err_d        = '0;
        end else begin
          phase_d = phase_q + 2'd1;
          state_d = StSettle;
        end
      end
      StLock: begin
        if (bus.i_start) begin
          sweep = 1'b1;
        end else if (TrackEn && tick_q) begin
          err_d = err_inc;
          if (cnt_q == WindowLast) begin
            cnt_d = '0;
            err_d = '0;
            sweep = (32'(err_inc) > THRESH);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (sweep) begin
      state_d    = StSettle;
      phase_d    = 2'd0;
      cnt_d      = '0;
      err_d      = '0;
      best_d     = 2'd0;
      best_err_d = ErrMax;
    end
  end

  assign bus.o_enable     = enable_q;
  assign bus.o_phase      = (state_q == StLock) ? lock_phase_q : phase_q;
  assign bus.o_busy       = (state_q == StSettle) || (state_q == StCount) || (state_q == StEval);
  assign bus.o_locked     = (state_q == StLock);
  assign bus.o_best_phase = lock_phase_q;
  assign bus.o_min_err    = lock_err_q;

endmodule

// File: tb/tb_rx_phase_ctrl.sv
// Randomised bench for rx_phase_ctrl: drives a PRBS9/constant line per phase and scores
// every sweep with a per-symbol error log and window arithmetic.
module tb_rx_phase_ctrl;
  localparam int unsigned NDiv      = 4;
  localparam int unsigned Settle    = 4;
  localparam int unsigned Window    = 64;
  localparam int unsigned ErrBits   = $clog2(Window + 1);
  localparam int unsigned Thresh    = 8;
  localparam int unsigned SweepSyms = 4 * (Settle + Window);
  localparam int unsigned ErrMax    = (1 << ErrBits) - 1;
  localparam int unsigned SymClks   = 4 * NDiv;

  logic clk = 1'b0;
  logic rst;

  rx_phase_ctrl_if #(.ERR_BITS(ErrBits)) bus ();

  rx_phase_ctrl #(
    .N_DIV   (NDiv),
    .SETTLE  (Settle),
    .WINDOW  (Window),
    .ERR_BITS(ErrBits),
    .THRESH  (Thresh)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc;
  int unsigned en_cnt;
  int unsigned sym_idx;
  bit          drove;
  logic [8:0]  hist;
  bit          err_log [0:16383];
  bit          ones_mask [4];
  int unsigned flip_pct [4];
  int unsigned inj_lo, inj_hi;
  int unsigned exp_best, exp_min;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One line symbol: constant 1 on masked phases, else the PRBS9 continuation of the line,
  // optionally corrupted. Its error flag is logged by the PRBS9 rule.
  task automatic drive_sym();
    logic [1:0] p;
    logic       pred, b;
    p    = bus.o_phase;
    pred = hist[8] ^ hist[4];
    if (ones_mask[p]) begin
      b = 1'b1;
    end else begin
      b = (hist == '0) ? 1'b1 : pred;
      if (bus.o_busy && ($urandom_range(99) < flip_pct[p])) b = ~b;
      if (sym_idx >= inj_lo && sym_idx < inj_hi && ((sym_idx - inj_lo) % 4) == 0) b = ~b;
    end
    bus.i_detection  = b;
    err_log[sym_idx] = (b != pred);
    hist             = {hist[7:0], b};
    sym_idx++;
    drove = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drove = 1'b0;
    if (rst) begin
      cyc++;
      check("enable", bus.o_enable, (cyc % NDiv) == 0);
      if (bus.o_enable) begin
        en_cnt = (en_cnt + 1) % 4;
        if (en_cnt == 0) drive_sym();
      end
    end
  endtask

  task automatic bench_reset_state();
    cyc    = 0;
    en_cnt = 0;
    hist   = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_enable", bus.o_enable, 0);
    check("rst_phase", bus.o_phase, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_locked", bus.o_locked, 0);
    check("rst_best", bus.o_best_phase, 0);
    check("rst_min_err", bus.o_min_err, 0);
  endtask

  task automatic start_sweep(output int unsigned k0);
    int unsigned n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!drove && n < 2 * SymClks);
    check("start_align", drove, 1);
    k0 = sym_idx - 1;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("start_busy", bus.o_busy, 1);
    check("start_locked", bus.o_locked, 0);
    check("start_phase", bus.o_phase, 0);
  endtask

  // Sweep starting at symbol k0: each phase owns Settle discarded symbols then Window counted.
  task automatic compute_expect(input int unsigned k0);
    int unsigned e;
    exp_best = 0;
    exp_min  = ErrMax;
    for (int p = 0; p < 4; p++) begin
      e = 0;
      for (int j = 0; j < Window; j++) e += err_log[k0 + p * (Settle + Window) + Settle + j];
      if (e > ErrMax) e = ErrMax;
      if (e < exp_min) begin
        exp_min  = e;
        exp_best = p;
      end
    end
  endtask

  task automatic wait_lock(input int unsigned k0);
    int unsigned n;
    n = 0;
    while (!bus.o_locked && n < SweepSyms * SymClks + 200) begin
      tick();
      n++;
    end
    check("lock_seen", bus.o_locked, 1);
    compute_expect(k0);
    check("lock_symbols", sym_idx, k0 + SweepSyms);
    check("best_phase", bus.o_best_phase, exp_best);
    check("min_err", bus.o_min_err, exp_min);
    check("lock_phase", bus.o_phase, exp_best);
    check("lock_busy", bus.o_busy, 0);
  endtask

  task automatic wait_until_sym(input int unsigned target);
    int unsigned n;
    n = 0;
    while (sym_idx < target && n < SweepSyms * SymClks) begin
      tick();
      n++;
    end
    check("sym_reached", sym_idx >= target, 1);
  endtask

  initial begin
    int unsigned k0, kl, old_best, old_min;
    bus.i_start     = 1'b0;
    bus.i_detection = 1'b0;
    inj_lo  = 0;
    inj_hi  = 0;
    sym_idx = 0;
    drove   = 1'b0;
    exp_best = 0;
    exp_min  = 0;
    for (int i = 0; i < 4; i++) begin
      ones_mask[i] = 1'b0;
      flip_pct[i]  = 0;
    end

    // Reset, divider phase, and asynchronous clear in the middle of an enable pulse.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    bench_reset_state();
    #20;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    repeat (8) tick();
    check("enable_clk8", bus.o_enable, 1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_pulse", bus.o_enable, 0);
    bench_reset_state();
    @(negedge clk);
    rst = 1'b1;
    repeat (12 * SymClks) tick();
    check("idle_busy", bus.o_busy, 0);
    check("idle_locked", bus.o_locked, 0);

    // Only phase 2 sees PRBS9; the others see a constant 1.
    ones_mask = '{1'b1, 1'b1, 1'b0, 1'b1};
    start_sweep(k0);
    wait_lock(k0);
    check("phase2_wins", exp_best, 2);

    // Corrupt every 4th bit for one lock-aligned window.
    kl     = sym_idx;
    inj_lo = kl;
    inj_hi = kl + Window;
`ifdef RX_PHASE_CTRL_TRACK_EN
    k0 = 0;
    while (bus.o_locked && k0 < (Window + 4) * SymClks) begin
      tick();
      k0++;
    end
    check("track_drop", bus.o_locked, 0);
    check("track_when", sym_idx, kl + Window);
    check("track_busy", bus.o_busy, 1);
    check("track_phase", bus.o_phase, 0);
    check("track_hold", bus.o_best_phase, exp_best);
    wait_lock(kl + Window);
`else
    repeat ((2 * Window + 4) * SymClks) tick();
    check("hold_locked", bus.o_locked, 1);
    check("hold_phase", bus.o_phase, exp_best);
`endif

    // Clean line on every phase, with an ignored mid-COUNT start.
    for (int i = 0; i < 4; i++) ones_mask[i] = 1'b0;
    old_best = exp_best;
    old_min  = exp_min;
    start_sweep(k0);
    check("resweep_best", bus.o_best_phase, old_best);
    check("resweep_min", bus.o_min_err, old_min);
    wait_until_sym(k0 + (Settle + Window) + Settle + 10);
    check("sweep_phase1", bus.o_phase, 1);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("ignored_busy", bus.o_busy, 1);
    check("ignored_phase", bus.o_phase, 1);
    wait_lock(k0);

    // Random per-phase corruption rates.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) flip_pct[i] = $urandom_range(12);
      old_best = exp_best;
      repeat ($urandom_range(40)) tick();
      start_sweep(k0);
      check("rand_hold_best", bus.o_best_phase, old_best);
      wait_lock(k0);
    end

    // Reset during phase-1 COUNT: everything clears, nothing restarts on its own.
    for (int i = 0; i < 4; i++) flip_pct[i] = 0;
    start_sweep(k0);
    wait_until_sym(k0 + (Settle + Window) + Settle + 20);
    check("pre_rst_phase", bus.o_phase, 1);
    repeat (3) tick();
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    bench_reset_state();
    #20;
    @(negedge clk);
    rst = 1'b1;
    repeat (20 * SymClks) tick();
    check("post_rst_busy", bus.o_busy, 0);
    check("post_rst_locked", bus.o_locked, 0);
    check("post_rst_phase", bus.o_phase, 0);
    check("post_rst_best", bus.o_best_phase, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
